// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the bit-counter width derived from the operand width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits never wrap mid-operation.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_subtractor_slice.sv
// One-bit full subtractor: d = a ^ b ^ bin, borrow out when a < b + bin.
module serial_sub_slice (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  wire axb;
  wire na;
  wire nab;
  wire naxb;
  wire prop;

  xor g_x0 (axb, a, b);
  xor g_x1 (d, axb, bin);
  not g_n0 (na, a);
  and g_a0 (nab, na, b);
  not g_n1 (naxb, axb);
  and g_a1 (prop, naxb, bin);
  or  g_o0 (bout, nab, prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin computed LSB first over WIDTH cycles
// on a single full-subtractor slice, with valid/ready handshakes on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never drops before that edge, and payload is held while valid.
  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             slice_d;
  logic             slice_bout;

  serial_sub_slice u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .d    (slice_d),
    .bout (slice_bout)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          diff   <= {slice_d, diff[WIDTH-1:1]};
          borrow <= slice_bout;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            bout      <= slice_bout;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Result stays on diff/bout until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: results are predicted with plain
// wide arithmetic at acceptance and checked by a monitor when presented.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = 0;
  bit rand_ready = 1'b0;

  logic [W:0] exp_q[$];
  int         acc_q[$];

  logic         prev_valid = 1'b0;
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_diff = '0;
  logic         prev_bout = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  // clock / cycle count / random consumer
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: borrow-out is bit W of the (W+1)-bit unsigned difference.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  // driver: called at posedge+#1; waits for in_ready, then presents one operand set
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
      return;
    end
    in_valid = 1'b1;
    a = x;
    b = y;
    bin = c;
    @(posedge clk); #1;
    exp_q.push_back(model(x, y, c));
    acc_q.push_back(cyc);
    last_acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || out_valid) check("drain_timeout", exp_q.size(), 0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("latency_unexpected", 32'd1, 32'd0);
        else check("latency", cyc - acc_q.pop_front(), W);
      end
      if (prev_hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_diff", {24'd0, diff}, {24'd0, prev_diff});
        check("hold_bout", {31'd0, bout}, {31'd0, prev_bout});
      end
      if (out_valid) check("in_ready_while_done", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("result_unexpected", {23'd0, bout, diff}, 32'h1ff);
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("diff", {24'd0, diff}, {24'd0, e[W-1:0]});
          check("bout", {31'd0, bout}, {31'd0, e[W]});
        end
      end
      prev_valid = out_valid;
      prev_hold = out_valid && !out_ready;
      prev_diff = diff;
      prev_bout = bout;
    end
  end

  logic [W-1:0] dir_a[4] = '{8'h03, 8'h00, 8'hFF, 8'h80};
  logic [W-1:0] dir_b[4] = '{8'h05, 8'h00, 8'h00, 8'h80};
  logic         dir_c[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int prev_acc;
    int n;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);

    // basic and boundary vectors
    out_ready = 1'b1;
    send(8'h05, 8'h03, 1'b0);
    wait_idle();
    check("idle_after_done", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      send(dir_a[i], dir_b[i], dir_c[i]);
      wait_idle();
    end

    // backpressure: result must hold for 5 stalled cycles
    out_ready = 1'b0;
    send(8'hA5, 8'h5A, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_still_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // in_valid with changing operands during RUN is ignored
    send(8'h3C, 8'h11, 1'b0);
    repeat (5) begin
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // back-to-back spacing
    send(8'h9A, 8'h21, 1'b1);
    prev_acc = last_acc;
    send(8'h01, 8'hF0, 1'b0);
    check("b2b_spacing", last_acc - prev_acc, W + 2);
    wait_idle();

    // reset mid-RUN aborts the operation
    send(8'h77, 8'h22, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_bout", {31'd0, bout}, 32'd0);
    send(8'h10, 8'h01, 1'b0);
    wait_idle();

    // randomized operands with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    wait_idle();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    check("final_idle", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
